// File: rtl/mix_pipe_pkg.sv
// Shared constants and helpers for the mix stage pipe.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default data/gate widths, buffered-entry layout ({flag, data}),
// flag bit index and the 16-bit saturation ceiling used by the stats counters.
package mix_pipe_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int GATE_W_DEF = 2;

  // Entry layout: flag sits directly above the data field.
  localparam int ENTRY_W  = DATA_W_DEF + 1;
  localparam int FLAG_BIT = DATA_W_DEF;

  localparam logic [15:0] SAT_MAX16 = 16'hFFFF;

  // Saturating 16-bit increment used by the optional stats counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == SAT_MAX16) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mix_pipe_fifo.sv
// Generic synchronous FIFO, DEPTH entries of W bits (DEPTH a power of 2, >= 2).
// Latency: 1 cycle write-to-read, no fall-through; rdata shows the head entry, 0 when empty.
// Backpressure: push ignored when full, pop ignored when empty; full/empty derive from level.
//
// Ports: clk, rst_n (async active-low), push, pop, wdata[W], rdata[W],
//        full, empty, level[$clog2(DEPTH+1)].
module mix_pipe_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is masked to 0 when empty so stale storage never leaks out.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: it is only observable through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // DEPTH is a power of 2, so pointers wrap naturally on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mix_stage_pipe.sv
// Streaming mix stage: each accepted beat becomes {&gate, data^key}, buffered in a DEPTH FIFO.
// Latency: 1 cycle minimum input-to-output (no fall-through); mon_active is 1 cycle after mon_bus.
// Backpressure: in_ready = !full, out_valid = !empty, both from occupancy only; head holds while stalled.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_key/in_gate;
//        out_valid/out_ready/out_data/out_flag; level; mon_bus -> mon_active;
//        beat_count/stall_count (live only with MIX_STATS_EN defined, otherwise tied to 0).
module mix_stage_pipe
  import mix_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int GATE_W = GATE_W_DEF,
  parameter int MON_W  = 16,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [DATA_W-1:0]           in_key,
  input  logic [GATE_W-1:0]           in_gate,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_flag,
  output logic [$clog2(DEPTH+1)-1:0]  level,
  input  logic [MON_W-1:0]            mon_bus,
  output logic                        mon_active,
  output logic [15:0]                 beat_count,
  output logic [15:0]                 stall_count
);

  // Entry is {flag, data}; flag index tracks the DATA_W parameter.
  localparam int EW = DATA_W + 1;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wdata     = {&in_gate, in_data ^ in_key};
  assign out_data  = rdata[DATA_W-1:0];
  assign out_flag  = rdata[DATA_W];

  mix_pipe_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_active <= 1'b0;
    end else begin
      mon_active <= |mon_bus;
    end
  end

`ifdef MIX_STATS_EN
  // Stall = head offered but not taken this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count  <= '0;
      stall_count <= '0;
    end else begin
      if (push)                    beat_count  <= sat_inc16(beat_count);
      if (out_valid && !out_ready) stall_count <= sat_inc16(stall_count);
    end
  end
`else
  assign beat_count  = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mix_stage_pipe.sv
// Self-checking bench for mix_stage_pipe: queue-based reference model plus directed vectors.
// Latency: model updates on the clock edge; outputs compared every falling edge.
// Backpressure: model accepts only when its queue has room and pops only when non-empty.
module tb_mix_stage_pipe;

  localparam int DATA_W = 8;
  localparam int GATE_W = 2;
  localparam int MON_W  = 16;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] in_key = '0;
  logic [GATE_W-1:0] in_gate = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_flag;
  logic [LVL_W-1:0]  level;
  logic [MON_W-1:0]  mon_bus = '0;
  logic              mon_active;
  logic [15:0]       beat_count;
  logic [15:0]       stall_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mix_stage_pipe #(
    .DATA_W (DATA_W),
    .GATE_W (GATE_W),
    .MON_W  (MON_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_key      (in_key),
    .in_gate     (in_gate),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flag    (out_flag),
    .level       (level),
    .mon_bus     (mon_bus),
    .mon_active  (mon_active),
    .beat_count  (beat_count),
    .stall_count (stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each queued item is {flag, result}; model state is just the queue.
  logic [DATA_W:0] q[$];
  logic            mon_exp   = 1'b0;
  int              beat_exp  = 0;
  int              stall_exp = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mon_exp   = 1'b0;
      beat_exp  = 0;
      stall_exp = 0;
    end else begin
      bit pushing, popping;
      pushing = in_valid && (q.size() < DEPTH);
      popping = out_ready && (q.size() > 0);
`ifdef MIX_STATS_EN
      if (pushing && beat_exp < 65535) beat_exp++;
      if (q.size() > 0 && !out_ready && stall_exp < 65535) stall_exp++;
`endif
      if (popping) void'(q.pop_front());
      if (pushing) q.push_back({(in_gate == '1), in_data ^ in_key});
      mon_exp = |mon_bus;
    end
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    logic [DATA_W:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
    chk("level",     32'(level),     32'(q.size()));
    chk("out_data",  32'(out_data),  32'(head[DATA_W-1:0]));
    chk("out_flag",  32'(out_flag),  32'(head[DATA_W]));
    chk("mon_active", 32'(mon_active), 32'(mon_exp));
    chk("beat_count", 32'(beat_count), 32'(beat_exp));
    chk("stall_count", 32'(stall_count), 32'(stall_exp));
  end

  // Advance to just after the next rising edge; inputs change here, away from the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [7:0] k, input logic [1:0] g);
    in_valid = v;
    in_data  = d;
    in_key   = k;
    in_gate  = g;
  endtask

  initial begin
    // ---- reset state ----
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_level",     32'(level),     32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_mon",       32'(mon_active), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // ---- 1: single beat, one-cycle latency ----
    drive(1'b1, 8'hA5, 8'h0F, 2'b11);
    #1;
    chk("t1_no_fallthrough", 32'(out_valid), 32'd0);
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data",  32'(out_data),  32'hAA);
    chk("t1_out_flag",  32'(out_flag),  32'd1);
    chk("t1_level",     32'(level),     32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_drained", 32'(level), 32'd0);

    // ---- 2: fill to DEPTH, 5th beat refused, FIFO drain order ----
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h10 + i * 8'h11), 8'h00, 2'b01);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    chk("t2_level_full", 32'(level),    32'd4);
    chk("t2_in_ready",   32'(in_ready), 32'd0);
    chk("t2_hold_data",  32'(out_data), 32'h10);
    step();
    chk("t2_head_stable", 32'(out_data), 32'h10);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain", 32'(out_data), 32'(8'(8'h10 + i * 8'h11)));
      step();
    end
    out_ready = 1'b0;
    chk("t2_empty", 32'(out_valid), 32'd0);
    chk("t2_empty_data", 32'(out_data), 32'd0);

    // ---- 3: simultaneous push/pop at level 2 across pointer wrap ----
    drive(1'b1, 8'h01, 8'h00, 2'b11); step();
    drive(1'b1, 8'h02, 8'h00, 2'b11); step();
    chk("t3_level2", 32'(level), 32'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 8'(8'h03 + i), 8'h00, 2'b11);
      step();
      chk("t3_level_hold", 32'(level), 32'd2);
      chk("t3_order", 32'(out_data), 32'(8'(8'h02 + i)));
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    step(); step();
    out_ready = 1'b0;
    chk("t3_drained", 32'(level), 32'd0);

    // ---- 4: gate AND and activity monitor ----
    drive(1'b1, 8'h3C, 8'hC3, 2'b10);
    mon_bus = 16'h0100;
    step();
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    chk("t4_data", 32'(out_data),   32'hFF);
    chk("t4_flag", 32'(out_flag),   32'd0);
    chk("t4_mon1", 32'(mon_active), 32'd1);
    mon_bus = 16'h0000;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_mon0", 32'(mon_active), 32'd0);

    // ---- 5: async reset with 3 entries buffered ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h70 + i), 8'h00, 2'b11);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    chk("t5_level3", 32'(level), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_level", 32'(level),     32'd0);
    chk("t5_async_data",  32'(out_data),  32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5_in_ready", 32'(in_ready),  32'd1);
    chk("t5_no_stale", 32'(out_valid), 32'd0);

    // ---- 6: stats counters ----
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h20 + i), 8'h00, 2'b11);
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    step(); step(); step();
`ifdef MIX_STATS_EN
    chk("t6_beats",  32'(beat_count),  32'd3);
    chk("t6_stalls", 32'(stall_count), 32'd5);
    for (int i = 0; i < 65535; i++) @(posedge clk);
    #2;
    chk("t6_stall_sat", 32'(stall_count), 32'hFFFF);
    step();
    chk("t6_stall_sat_hold", 32'(stall_count), 32'hFFFF);
`else
    chk("t6_beats_off",  32'(beat_count),  32'd0);
    chk("t6_stalls_off", 32'(stall_count), 32'd0);
`endif
    out_ready = 1'b1;
    step(); step(); step();
    out_ready = 1'b0;
    chk("t6_drained", 32'(level), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
